// File: rtl/aes_dec_pkg.sv
// Shared types, round-count constants and GF(2^8) helpers for the iterative AES inverse cipher.
// Byte i of a 128-bit state occupies bits [8*i : 8*i+7], column-major (byte = row + 4*column).
package aes_dec_pkg;

    typedef logic [0:127] aes_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } inv_fsm_e;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gfMul(p, p);
            r = gfMul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] y);
        logic [7:0] a;
        a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gfInv(a);
    endfunction

    function automatic aes_state_t inverse_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t o;
        o = s;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = invSbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        o = s;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
            o[32*c + 8  +: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
            o[32*c + 16 +: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
            o[32*c + 24 +: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round_chk.sv
// Property checker for the round sequencer: the round counter never sits at zero inside ROUND.
module aes_inv_round_chk
    import aes_dec_pkg::*;
(
    input logic       clk,
    input logic       reset_n,
    input inv_fsm_e   fsm,
    input logic [3:0] rnd
);

    aRndNonZero: assert property (@(posedge clk) disable iff (!reset_n)
        (fsm == ROUND) |-> (rnd != 4'd0));

endmodule

// File: rtl/aes_inv_round_dp.sv
// One inverse-cipher round, purely combinational; the last round skips InvMixColumns.
module aes_inv_round_dp
    import aes_dec_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       last_round,
    output aes_state_t next_state
);

    aes_state_t addKey;

    // Round transform: shift, substitute, add key, then mix unless this is the last round.
    always_comb begin
        addKey     = inv_sub_bytes(inverse_shift_rows(state)) ^ round_key;
        next_state = addKey;
        if (last_round) begin
            next_state = addKey;
        end else begin
            next_state = inv_mix_columns(addKey);
        end
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock over a single state register.
// Optional abort path enabled by defining AES_INV_FLUSH_EN (adds the flush input).
module aes_inv_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   key_idx,
    input  logic [0:127] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
`ifdef AES_INV_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    generate
        if (NR != AES128_NR && NR != AES192_NR && NR != AES256_NR) begin : gNrCheck
            $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_IDX    = 4'(NR);
    localparam logic [3:0] RND_START = 4'(NR - 1);

    inv_fsm_e   fsmReg;
    aes_state_t stateReg;
    aes_state_t dpNext;
    logic [3:0] rndReg;
    logic [3:0] keyIdxReg;
    logic       inReadyReg;
    logic       outValidReg;
    logic       busyReg;
    logic       lastRound;
    logic       flushReq;

`ifdef AES_INV_FLUSH_EN
    assign flushReq = flush;
`else
    assign flushReq = 1'b0;
`endif

    assign lastRound = (fsmReg == FINAL);

    aes_inv_round_dp uDp (
        .state      (stateReg),
        .round_key  (round_key),
        .last_round (lastRound),
        .next_state (dpNext)
    );

    aes_inv_round_chk uChk (
        .clk     (clk),
        .reset_n (reset_n),
        .fsm     (fsmReg),
        .rnd     (rndReg)
    );

    // Sequencer: state register, round counter and all handshake/key outputs, registered on the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsmReg      <= IDLE;
            stateReg    <= 128'h0;
            rndReg      <= 4'd0;
            keyIdxReg   <= NR_IDX;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
        end else if (flushReq) begin
            fsmReg      <= IDLE;
            stateReg    <= 128'h0;
            rndReg      <= 4'd0;
            keyIdxReg   <= NR_IDX;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
        end else begin
            case (fsmReg)
                IDLE: begin
                    if (in_valid && inReadyReg) begin
                        stateReg   <= in_data ^ round_key;
                        rndReg     <= RND_START;
                        keyIdxReg  <= RND_START;
                        fsmReg     <= ROUND;
                        inReadyReg <= 1'b0;
                        busyReg    <= 1'b1;
                    end else begin
                        fsmReg <= IDLE;
                    end
                end
                ROUND: begin
                    stateReg <= dpNext;
                    rndReg   <= rndReg - 4'd1;
                    if (rndReg == 4'd1) begin
                        fsmReg    <= FINAL;
                        keyIdxReg <= 4'd0;
                    end else begin
                        fsmReg    <= ROUND;
                        keyIdxReg <= rndReg - 4'd1;
                    end
                end
                FINAL: begin
                    stateReg    <= dpNext;
                    fsmReg      <= DONE;
                    outValidReg <= 1'b1;
                end
                DONE: begin
                    // Acceptance of the next block waits for IDLE, one cycle after this handshake.
                    if (out_ready) begin
                        fsmReg      <= IDLE;
                        keyIdxReg   <= NR_IDX;
                        inReadyReg  <= 1'b1;
                        outValidReg <= 1'b0;
                        busyReg     <= 1'b0;
                    end else begin
                        fsmReg <= DONE;
                    end
                end
                default: begin
                    fsmReg      <= IDLE;
                    stateReg    <= 128'h0;
                    rndReg      <= 4'd0;
                    keyIdxReg   <= NR_IDX;
                    inReadyReg  <= 1'b1;
                    outValidReg <= 1'b0;
                    busyReg     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign out_data  = stateReg;
    assign busy      = busyReg;
    assign key_idx   = keyIdxReg;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl: known-answer vectors with NR=10 and NR=14, backpressure,
// back-to-back offers, mid-round reset and (with AES_INV_FLUSH_EN) flush abort.
module tb_aes_inv_round_ctrl;

    typedef struct {
        logic [0:127] key;
        logic [0:127] ct;
        logic [0:127] pt;
        int           stall;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic         inValid10, inReady10, outValid10, outReady10, busy10;
    logic [0:127] inData10, roundKey10, outData10;
    logic [3:0]   keyIdx10;
    logic         inValid14, inReady14, outValid14, outReady14, busy14;
    logic [0:127] inData14, roundKey14, outData14;
    logic [3:0]   keyIdx14;
`ifdef AES_INV_FLUSH_EN
    logic         flush10, flush14;
`endif

    logic [0:127] w10 [0:15];
    logic [0:127] w14 [0:15];
    logic [0:127] rkTmp [0:15];
    logic [0:127] expQ10 [$];
    logic [0:127] expQ14 [$];
    vec_t         vecs [4];

    assign roundKey10 = w10[keyIdx10];
    assign roundKey14 = w14[keyIdx14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_round_ctrl #(.NR(10)) dut10 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid10), .in_ready(inReady10), .in_data(inData10),
        .key_idx(keyIdx10), .round_key(roundKey10), .out_valid(outValid10), .out_ready(outReady10),
        .out_data(outData10), .busy(busy10)
`ifdef AES_INV_FLUSH_EN
        , .flush(flush10)
`endif
    );

    aes_inv_round_ctrl #(.NR(14)) dut14 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid14), .in_ready(inReady14), .in_data(inData14),
        .key_idx(keyIdx14), .round_key(roundKey14), .out_valid(outValid14), .out_ready(outReady14),
        .out_data(outData14), .busy(busy14)
`ifdef AES_INV_FLUSH_EN
        , .flush(flush14)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, p;
        acc = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xt(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, p;
        inv = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // FIPS-197 key expansion into rkTmp[0..Nr]
    task automatic expandKey(input logic [0:255] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          total;
        total = 4 * (nk + 7);
        rcon = 8'h01;
        for (int r = 0; r < 16; r++) rkTmp[r] = 128'h0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < nk + 7; r++) rkTmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] popExp10();
        if (expQ10.size() == 0) return 128'h0;
        return expQ10.pop_front();
    endfunction

    // Full transaction on the NR=10 instance, with optional output stall.
    task automatic runVec10(input vec_t v, input int idx);
        int acc;
        bit keyOk, got, holdOk;
        expandKey({v.key, 128'h0}, 4);
        for (int r = 0; r < 16; r++) w10[r] = rkTmp[r];
        outReady10 = (v.stall == 0);
        check($sformatf("vec%0d_idle", idx), {inReady10, outValid10, busy10, keyIdx10}, {1'b1, 1'b0, 1'b0, 4'd10});
        inData10 = v.ct;
        inValid10 = 1'b1;
        expQ10.push_back(v.pt);
        @(negedge clk);
        inValid10 = 1'b0;
        acc = cyc;
        keyOk = 1'b1;
        got = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (outValid10) begin got = 1'b1; break; end
            if (keyIdx10 !== 4'(9 - j) || inReady10 !== 1'b0) keyOk = 1'b0;
            @(negedge clk);
        end
        check($sformatf("vec%0d_keyseq", idx), keyOk, 1'b1);
        check($sformatf("vec%0d_latency", idx), got ? (cyc - acc) : -1, 10);
        holdOk = 1'b1;
        for (int s = 0; s < v.stall; s++) begin
            if (outValid10 !== 1'b1 || outData10 !== v.pt || inReady10 !== 1'b0) holdOk = 1'b0;
            @(negedge clk);
        end
        if (v.stall > 0) check($sformatf("vec%0d_hold", idx), holdOk, 1'b1);
        outReady10 = 1'b1;
        check($sformatf("vec%0d_data", idx), outData10, popExp10());
        @(negedge clk);
        check($sformatf("vec%0d_back_idle", idx), {inReady10, outValid10, busy10, keyIdx10}, {1'b1, 1'b0, 1'b0, 4'd10});
    endtask

    task automatic waitPop10(input string tag);
        bit got;
        got = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (outValid10) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_valid"}, got, 1'b1);
        check({tag, "_data"}, outData10, popExp10());
        @(negedge clk);
    endtask

    task automatic waitKey10(input logic [3:0] k, input string tag);
        bit found;
        found = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (keyIdx10 == k) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, found, 1'b1);
    endtask

    task automatic runVec14(input logic [0:127] ct, input logic [0:127] pt);
        int acc;
        bit keyOk, got;
        outReady14 = 1'b1;
        check("c3_idle", {inReady14, keyIdx14}, {1'b1, 4'd14});
        inData14 = ct;
        inValid14 = 1'b1;
        expQ14.push_back(pt);
        @(negedge clk);
        inValid14 = 1'b0;
        acc = cyc;
        keyOk = 1'b1;
        got = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (outValid14) begin got = 1'b1; break; end
            if (keyIdx14 !== 4'(13 - j)) keyOk = 1'b0;
            @(negedge clk);
        end
        check("c3_keyseq", keyOk, 1'b1);
        check("c3_latency", got ? (cyc - acc) : -1, 14);
        check("c3_data", outData14, (expQ14.size() > 0) ? expQ14.pop_front() : 128'h0);
        @(negedge clk);
        check("c3_back_idle", {inReady14, outValid14, busy14}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2;
        bit sawOut;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff, 0};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 5};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 2};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a, 0};
        inValid10 = 1'b0; inData10 = 128'h0; outReady10 = 1'b1;
        inValid14 = 1'b0; inData14 = 128'h0; outReady14 = 1'b1;
`ifdef AES_INV_FLUSH_EN
        flush10 = 1'b0; flush14 = 1'b0;
`endif
        expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        for (int r = 0; r < 16; r++) w10[r] = rkTmp[r];
        expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        for (int r = 0; r < 16; r++) w14[r] = rkTmp[r];

        repeat (2) @(negedge clk);
        check("rst10_ctrl", {inReady10, outValid10, busy10, keyIdx10}, {1'b1, 1'b0, 1'b0, 4'd10});
        check("rst10_data", outData10, 128'h0);
        check("rst14_ctrl", {inReady14, outValid14, busy14, keyIdx14}, {1'b1, 1'b0, 1'b0, 4'd14});
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) runVec10(vecs[i], i);
        runVec14(128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff);

        // Second block offered continuously while the first is in flight.
        expandKey({vecs[1].key, 128'h0}, 4);
        for (int r = 0; r < 16; r++) w10[r] = rkTmp[r];
        outReady10 = 1'b1;
        inData10 = vecs[1].ct;
        inValid10 = 1'b1;
        expQ10.push_back(vecs[1].pt);
        @(negedge clk);
        acc1 = cyc;
        acc2 = -1;
        inData10 = vecs[3].ct;
        sawOut = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (outValid10) begin
                check("ii_first_data", outData10, popExp10());
                sawOut = 1'b1;
            end else if (inReady10) begin
                expQ10.push_back(vecs[3].pt);
                @(negedge clk);
                acc2 = cyc;
                break;
            end
            @(negedge clk);
        end
        inValid10 = 1'b0;
        check("ii_order", sawOut, 1'b1);
        check("ii_spacing", acc2 - acc1, 12);
        waitPop10("ii_second");

        // Reset in the middle of a block.
        expandKey({vecs[0].key, 128'h0}, 4);
        for (int r = 0; r < 16; r++) w10[r] = rkTmp[r];
        inData10 = vecs[0].ct;
        inValid10 = 1'b1;
        expQ10.push_back(vecs[0].pt);
        @(negedge clk);
        inValid10 = 1'b0;
        waitKey10(4'd5, "rst_reach_rnd5");
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", {inReady10, outValid10, busy10, keyIdx10}, {1'b1, 1'b0, 1'b0, 4'd10});
        check("midrst_data", outData10, 128'h0);
        expQ10.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        runVec10(vecs[0], 8);

`ifdef AES_INV_FLUSH_EN
        inData10 = vecs[0].ct;
        inValid10 = 1'b1;
        expQ10.push_back(vecs[0].pt);
        @(negedge clk);
        inValid10 = 1'b0;
        waitKey10(4'd3, "flush_reach_rnd3");
        flush10 = 1'b1;
        @(negedge clk);
        flush10 = 1'b0;
        check("flush_ctrl", {inReady10, outValid10, busy10, keyIdx10}, {1'b1, 1'b0, 1'b0, 4'd10});
        check("flush_state", outData10, 128'h0);
        expQ10.delete();
        sawOut = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (outValid10) sawOut = 1'b1;
        end
        check("flush_no_valid", sawOut, 1'b0);
        runVec10(vecs[0], 9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
